// File: rtl/adpll_tdc_pkg.sv
// Shared constants and types for the ADPLL TDC digital back end.
package adpll_tdc_pkg;

    localparam int RIPPLE_W = 7;
    localparam int TAPS     = 16;
    localparam int WORD_W   = 12;
    localparam int BCNT_W   = 8;

    typedef logic [3:0] tdc_pos_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } tdc_state_e;

endpackage

// File: rtl/adpll_tdc_decode_if.sv
// Bundle between tdc_analog (master side) and the TDC decoder (slave side).
interface adpll_tdc_decode_if;
    import adpll_tdc_pkg::*;

    logic                en;
    logic [RIPPLE_W-1:0] tdc_ripple_count;
    logic [TAPS-1:0]     tdc_phase;
    logic [WORD_W-1:0]   tdc_word;
    logic                tdc_word_valid;
    logic                no_edge;
    logic [BCNT_W-1:0]   bubble_cnt;

    modport master (
        output en, tdc_ripple_count, tdc_phase,
        input  tdc_word, tdc_word_valid, no_edge, bubble_cnt
    );

    modport slave (
        input  en, tdc_ripple_count, tdc_phase,
        output tdc_word, tdc_word_valid, no_edge, bubble_cnt
    );

endinterface

// File: rtl/tdc_therm_decode.sv
// Bubble-corrects a delay-line thermometer snapshot and finds its first 1->0 edge.
module tdc_therm_decode
    import adpll_tdc_pkg::*;
(
    input  logic [TAPS-1:0] phase_i,
    output tdc_pos_t        pos_o,
    output logic            no_edge_o,
    output logic            bubble_o
);

    // End taps replicate their neighbour so the filter window never leaves the line.
    logic [TAPS+1:0] ext;
    logic [TAPS-1:0] corr;

    assign ext = {phase_i[TAPS-1], phase_i, phase_i[0]};

    // Three-tap majority vote removes isolated bubbles.
    always_comb begin
        corr = '0;
        for (int i = 0; i < TAPS; i++) begin
            corr[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
    end

    assign bubble_o = (corr != phase_i);

    // Scan downward so the lowest 1->0 transition is the one that sticks.
    always_comb begin
        pos_o     = '0;
        no_edge_o = 1'b1;
        for (int i = TAPS - 1; i >= 1; i--) begin
            if (corr[i-1] && !corr[i]) begin
                pos_o     = tdc_pos_t'(i);
                no_edge_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/adpll_tdc_decode.sv
// TDC back end: capture, decode, and difference consecutive samples into tdc_word.
module adpll_tdc_decode
    import adpll_tdc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    adpll_tdc_decode_if.slave  tdc_if
);

    logic [TAPS-1:0]     ph_a_q;
    logic [RIPPLE_W-1:0] rc_a_q;
    logic                en_a_q;

    tdc_pos_t            pos_b_q, pos_p_q;
    logic [RIPPLE_W-1:0] rc_b_q, rc_p_q;
    logic                en_b_q, en_p_q;
    logic                no_edge_b_q;

    logic [WORD_W-1:0]   word_q;
    logic                valid_q;
    logic                no_edge_q;
    logic [BCNT_W-1:0]   bcnt_q;
    tdc_state_e          state_q;

    tdc_pos_t            pos_d;
    logic                no_edge_d;
    logic                bubble_d;
    logic [RIPPLE_W-1:0] rc_delta_d;
    logic [WORD_W-1:0]   word_d;

    tdc_therm_decode u_therm (
        .phase_i   (ph_a_q),
        .pos_o     (pos_d),
        .no_edge_o (no_edge_d),
        .bubble_o  (bubble_d)
    );

    // Ripple difference wraps mod 128; fractional taps are appended in 1/16 units.
    assign rc_delta_d = rc_b_q - rc_p_q;
    assign word_d     = WORD_W'({rc_delta_d, 4'b0000}) + WORD_W'(pos_p_q) - WORD_W'(pos_b_q);

    // Stage A: register the raw analog snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_a_q <= '0;
            rc_a_q <= '0;
            en_a_q <= 1'b0;
        end else begin
            ph_a_q <= tdc_if.tdc_phase;
            rc_a_q <= tdc_if.tdc_ripple_count;
            en_a_q <= tdc_if.en;
        end
    end

    // Stage B: decoded current sample, with the previous one shifted into the p registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_b_q     <= '0;
            rc_b_q      <= '0;
            en_b_q      <= 1'b0;
            no_edge_b_q <= 1'b0;
            pos_p_q     <= '0;
            rc_p_q      <= '0;
            en_p_q      <= 1'b0;
        end else begin
            pos_b_q     <= pos_d;
            rc_b_q      <= rc_a_q;
            en_b_q      <= en_a_q;
            no_edge_b_q <= no_edge_d;
            pos_p_q     <= pos_b_q;
            rc_p_q      <= rc_b_q;
            en_p_q      <= en_b_q;
        end
    end

    // Output stage: phase increment and the edge flag of the same sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q    <= '0;
            no_edge_q <= 1'b0;
        end else begin
            word_q    <= word_d;
            no_edge_q <= no_edge_b_q;
        end
    end

    // Saturating count of enabled samples that needed bubble correction.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt_q <= '0;
        end else if (en_a_q && bubble_d && (bcnt_q != {BCNT_W{1'b1}})) begin
            bcnt_q <= bcnt_q + 1'b1;
        end
    end

    // Enable sequencing: a word is valid only once two enabled samples are in hand.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= en_b_q ? PRIME : IDLE;
                    valid_q <= 1'b0;
                end
                PRIME, RUN: begin
                    if (!en_b_q) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end else if (en_p_q) begin
                        state_q <= RUN;
                        valid_q <= 1'b1;
                    end else begin
                        state_q <= PRIME;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign tdc_if.tdc_word       = word_q;
    assign tdc_if.tdc_word_valid = valid_q;
    assign tdc_if.no_edge        = no_edge_q;
    assign tdc_if.bubble_cnt     = bcnt_q;

endmodule
